hazard_stall_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage core. Generates the stall and flush controls for the IF/ID register, the PC write-enable and the ID/EX bubble. It sequences three hazard sources:
- load-use data hazards;
- HI/LO and back-to-back hazards from the multi-cycle multiply/divide unit (MDU);
- taken-branch flushes.

---
 rtl/hazard_stall_ctrl.sv | 93 +++++++++
 tb/tb_hazard_stall_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the 5-stage core: load-use and MDU stalls, taken-branch IF/ID flush.
// Define HAZARD_PERF_CNT_EN to add the stall_cycles / flush_count performance counters.
module hazard_stall_ctrl #(
  parameter int unsigned MDU_LATENCY = 32,
  parameter int unsigned CNT_W       = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_hilo_read,
  input  logic       id_mdu_op,
  input  logic       id_branch_taken,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       ex_mdu_start,
  output logic       pc_write,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic       mdu_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MDU_LATENCY - 1);

  logic [CNT_W-1:0] r_mdu_cnt;
  logic             w_busy;
  logic             w_lu;
  logic             w_mh;
  logic             w_stall;

  // A load only blocks its consumer for the single cycle before it moves on to MEM.
  assign w_busy  = (r_mdu_cnt != '0);
  assign w_lu    = ex_mem_read & (ex_rt != 5'd0) &
                   ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  assign w_mh    = w_busy & (id_hilo_read | id_mdu_op);
  assign w_stall = w_lu | w_mh;

  // A new MDU start reloads the counter even while a previous op is still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mdu_cnt <= '0;
    end else if (ex_mdu_start) begin
      r_mdu_cnt <= CNT_RELOAD;
    end else if (w_busy) begin
      r_mdu_cnt <= r_mdu_cnt - CNT_W'(1);
    end
  end

  // Branch outcome is ignored during a stall since its operands may be stale.
  always_comb begin
    pc_write     = 1'b1;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    mdu_busy     = 1'b0;
    if (!reset) begin
      mdu_busy = w_busy;
      if (w_stall) begin
        pc_write     = 1'b0;
        if_id_stall  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (id_branch_taken) begin
        if_id_flush = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= 32'd0;
      r_flush_count  <= 32'd0;
    end else begin
      if (if_id_stall) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (if_id_flush) r_flush_count  <= r_flush_count + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: per-cycle expected controls queued at drive, checked at negedge.
module tb_hazard_stall_ctrl;

  localparam int unsigned MDU_LATENCY = 32;
  localparam int unsigned CNT_W       = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, id_hilo_read, id_mdu_op, id_branch_taken;
  logic       ex_mem_read, ex_mdu_start;
  logic       pc_write, if_id_stall, if_id_flush, id_ex_bubble, mdu_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  hazard_stall_ctrl #(.MDU_LATENCY(MDU_LATENCY), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_hilo_read(id_hilo_read), .id_mdu_op(id_mdu_op),
    .id_branch_taken(id_branch_taken),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_mdu_start(ex_mdu_start),
    .pc_write(pc_write), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .mdu_busy(mdu_busy)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         m_cnt = 0;
  int         m_stall = 0;
  int         m_flush = 0;
  logic [4:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {pc_write, if_id_stall, if_id_flush, id_ex_bubble, mdu_busy}
  function automatic logic [4:0] model_exp();
    logic lu, mh, busy;
    if (reset) return 5'b10000;
    busy = (m_cnt > 0);
    lu = ex_mem_read && (ex_rt != 5'd0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    mh = busy && (id_hilo_read || id_mdu_op);
    if (lu || mh) return {4'b0101, busy};
    if (id_branch_taken) return {4'b1010, busy};
    return {4'b1000, busy};
  endfunction

  task automatic cycle(input string tag, output logic [4:0] got);
    logic [4:0] e;
    exp_q.push_back(model_exp());
    @(negedge clk);
    got = {pc_write, if_id_stall, if_id_flush, id_ex_bubble, mdu_busy};
    e = exp_q.pop_front();
    check_val(tag, 32'(got), 32'(e));
    if (!reset && e[3]) m_stall++;
    if (!reset && e[2]) m_flush++;
    @(posedge clk);
    if (reset) m_cnt = 0;
    else if (ex_mdu_start) m_cnt = MDU_LATENCY - 1;
    else if (m_cnt > 0) m_cnt--;
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rt = 1'b0; id_hilo_read = 1'b0; id_mdu_op = 1'b0;
    id_branch_taken = 1'b0; ex_mem_read = 1'b0; ex_mdu_start = 1'b0;
  endtask

  initial begin
    logic [4:0] g;
    int         stalls;
    int         rel;
    int         guard;

    idle();
    reset = 1'b1;
    ex_mdu_start = 1'b1;
    @(posedge clk); #1;
    cycle("rst_hold0", g);
    cycle("rst_hold1", g);
    reset = 1'b0; ex_mdu_start = 1'b0; id_hilo_read = 1'b1;
    cycle("post_rst_no_busy", g);
    check_val("post_rst_busy_bit", 32'(g[0]), 32'd0);

    // load-use
    idle(); ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    cycle("lu_hit", g);
    check_val("lu_hit_pc_write", 32'(g[4]), 32'd0);
    ex_mem_read = 1'b0;
    cycle("lu_release", g);
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    cycle("lu_r0", g);
    ex_rt = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b0;
    cycle("lu_rt_unused", g);
    id_uses_rt = 1'b1;
    cycle("lu_rt_used", g);

    // branch
    idle(); id_branch_taken = 1'b1;
    cycle("br_flush", g);
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    cycle("br_in_stall", g);
    check_val("br_in_stall_flush", 32'(g[2]), 32'd0);
    ex_mem_read = 1'b0;
    cycle("br_after_stall", g);
    check_val("br_after_stall_flush", 32'(g[2]), 32'd1);
`ifdef HAZARD_PERF_CNT_EN
    check_val("perf_stall_cycles", stall_cycles, 32'(m_stall));
    check_val("perf_flush_count", flush_count, 32'(m_flush));
`endif

    // MDU latency on a dependent mfhi
    idle(); ex_mdu_start = 1'b1;
    cycle("mdu_start", g);
    ex_mdu_start = 1'b0; id_hilo_read = 1'b1;
    stalls = 0; rel = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle("mdu_wait", g);
      if (g[4]) begin
        rel = i;
        break;
      end
      stalls++;
    end
    check_val("mdu_stall_len", 32'(stalls), 32'(MDU_LATENCY - 1));
    check_val("mdu_release_cycle", 32'(rel), 32'(MDU_LATENCY));

    // restart while busy
    idle(); ex_mdu_start = 1'b1;
    cycle("restart_first", g);
    ex_mdu_start = 1'b0; id_mdu_op = 1'b1;
    guard = 0;
    while (m_cnt != 5 && guard < 40) begin
      cycle("restart_count", g);
      guard++;
    end
    ex_mdu_start = 1'b1;
    cycle("restart_at5", g);
    ex_mdu_start = 1'b0;
    cycle("restart_busy", g);
    check_val("restart_no_gap", 32'(g[0]), 32'd1);

    // simultaneous load-use and MDU hazards
    ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
    cycle("lu_and_mh", g);
    ex_mem_read = 1'b0;
    cycle("mh_only", g);
    id_mdu_op = 1'b0; id_branch_taken = 1'b1;
    cycle("br_while_busy_no_hazard", g);
    id_branch_taken = 1'b0;

    // reset mid-wait
    guard = 0;
    id_hilo_read = 1'b1;
    while (m_cnt != 10 && guard < 40) begin
      cycle("to_cnt10", g);
      guard++;
    end
    reset = 1'b1;
    cycle("rst_mid_wait", g);
    reset = 1'b0;
    cycle("rst_mid_after", g);
    check_val("rst_mid_busy", 32'(g[0]), 32'd0);
    check_val("rst_mid_pc_write", 32'(g[4]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
